spi_tx_arbiter: RTL
===================

# spi_tx_arbiter

Round-robin arbiter and sequencer that shares the single byte-serial SPI transmitter among `N_REQ` on-chip producers (hash and cipher units). It grants one requester a whole frame (one or more bytes, ended by a `last` flag) and hands the serializer one byte at a time through a load/ready handshake. It drives `frame_active` for the frame-level select line and enforces a minimum idle gap between frames. If a granted requester stalls mid-frame, the frame is aborted after a timeout.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `GAP_CYCLES`, 4: idle clocks between frames, 1..255.
- `TIMEOUT`, 255: maximum wait in `WAIT_DATA`/`WAIT_START` before abort, 1..255.
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req`  in  N_REQ  requester i has a byte ready; held with data until `ack[i]`.
- `req_data`  in  8*N_REQ  byte of requester i at bits [8i+7:8i].
- `req_last`  in  N_REQ  byte presented by requester i is the final byte of its frame.
- `gnt`  out  N_REQ  one-hot frame grant; all zero when no frame is in progress.
- `ack`  out  N_REQ  one-cycle pulse: byte of requester i consumed.
- `tx_data`  out  8  byte to the serializer; valid while `tx_load`=1.
- `tx_load`  out  1  one-cycle pulse: serializer must take `tx_data`.
- `tx_ready`  in  1  serializer is idle or has finished its byte (high = sent).
- `frame_active`  out  1  high from first load to frame end or abort.
- `abort`  out  1  one-cycle pulse: frame terminated by timeout.

## Operation
- All outputs are registered. Reset values: `gnt`=0, `ack`=0, `tx_data`=0, `tx_load`=0, `frame_active`=0, `abort`=0, RR pointer=0, timer=0, state=`IDLE`.
- `IDLE`: if any `req` is high, choose the first set bit starting at the pointer, wrapping modulo N_REQ. Set `gnt` and move to `LOAD`.
- `LOAD`: if `req[g]`=1 and `tx_ready`=1:
  - pulse `tx_load` and `ack[g]`;
  - register `tx_data=req_data[g]` and the `last` flag;
  - set `frame_active`=1;
  - go to `WAIT_START`.
- `LOAD` with `req[g]`=0: go to `WAIT_DATA`. With `req[g]`=1 and `tx_ready`=0: stay in `LOAD`.
- `WAIT_START`: wait for `tx_ready`=0 (serializer has accepted the byte), then go to `WAIT_DONE`. The timer runs; expiry triggers abort.
- `WAIT_DONE`: wait for `tx_ready`=1. No timeout. Then:
  - last flag set: clear `gnt` and `frame_active`, set pointer=g+1 mod N_REQ, go to `GAP`;
  - otherwise go to `LOAD`.
- `WAIT_DATA`: return to `LOAD` when `req[g]`=1. The timer runs.
- Abort, on timer reaching TIMEOUT: pulse `abort`; clear `gnt` and `frame_active`; set pointer=g+1; go to `GAP`. The partial frame is not retried.
- `GAP`: count GAP_CYCLES clocks, then go to `IDLE`. Requests are ignored in this state.
- Timer: 8-bit. Cleared on every state entry, incremented only in `WAIT_START` and `WAIT_DATA`, never wraps.
- A requester whose `req` falls without an `ack` is simply not served. Data is never taken without `ack`.
- `rst` overrides everything. An in-flight frame is dropped with no `ack` and no `abort`.

## Timing
- Request-to-grant: `req` sampled in `IDLE` at edge t gives `gnt` at t+1. With `tx_ready`=1, `tx_load` and `ack` go high at t+2.
- Byte-to-byte: the next `tx_load` comes 2 clocks after `tx_ready` rises in `WAIT_DONE` (`WAIT_DONE`→`LOAD`→pulse).
- Frame end: `gnt` and `frame_active` fall 1 clock after the final `tx_ready` rise. The earliest next grant follows GAP_CYCLES+1 clocks later.
- Simultaneous requests are resolved by pointer order only. A single requester may win back-to-back frames, separated by the gap.

## Structure
- Shared package `spi_pkg`:
  - state enum `IDLE`, `LOAD`, `WAIT_START`, `WAIT_DONE`, `WAIT_DATA`, `GAP`;
  - byte width constant 8;
  - timer width constant 8.
- Sub-module `rr_pick`: combinational N_REQ-wide round-robin priority picker with inputs req and ptr, outputs one-hot and index.

## Test plan
- Single requester, 3-byte frame 0xA5, 0x3C, 0x81 (last on 0x81), with a serializer model (ready low 24 clocks per byte):
  - three `tx_load` pulses carrying those bytes in order;
  - three `ack[0]` pulses;
  - `frame_active` high from the first load until 1 clock after the final ready rise.
- All four requesters high with 1-byte frames, pointer 0: grant order 0, 1, 2, 3, 0; exactly 4 gap clocks between frames.
- Requester 2 mid-frame drops `req` for 300 clocks:
  - `abort` pulses once, 255 clocks after entering `WAIT_DATA`;
  - `gnt` clears and the next grant goes to requester 3.
- `tx_ready` held high after `tx_load`: `abort` after 255 clocks in `WAIT_START`; no second `ack`.
- `rst` asserted during `WAIT_DONE`: the next clock shows all outputs 0 and state `IDLE`, with no `abort`. After release with `req[1]` set, `gnt[1]` appears 1 clock later (pointer=0, so requester 1 is the first requester found).
- `req_last` set on the first byte: a single `tx_load`, then the frame closes.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI transmit arbiter: sequencer states and datapath widths.
package spi_pkg;

  localparam int BYTE_W  = 8;
  localparam int TIMER_W = 8;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LOAD       = 3'd1,
    WAIT_START = 3'd2,
    WAIT_DONE  = 3'd3,
    WAIT_DATA  = 3'd4,
    GAP        = 3'd5
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping modulo N_REQ.
module rr_pick
  import spi_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IW    = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IW-1:0]    ptr_i,
  output logic [N_REQ-1:0] onehot_o,
  output logic [IW-1:0]    idx_o,
  output logic             any_o
);

  int          j;
  logic [IW-1:0] cand;
  logic        found;

  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    found    = 1'b0;
    j        = 0;
    cand     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      j = int'(ptr_i) + i;
      if (j >= N_REQ) j = j - N_REQ;
      cand = IW'(j);
      if (!found && req_i[cand]) begin
        found           = 1'b1;
        onehot_o[cand]  = 1'b1;
        idx_o           = cand;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/spi_tx_arbiter.sv
// Round-robin frame arbiter feeding a byte-serial SPI transmitter, with inter-frame gap
// and a stall timeout that aborts a frame whose owner or serializer stops making progress.
module spi_tx_arbiter
  import spi_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int GAP_CYCLES = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req,
  input  logic [8*N_REQ-1:0]    req_data,
  input  logic [N_REQ-1:0]      req_last,
  output logic [N_REQ-1:0]      gnt,
  output logic [N_REQ-1:0]      ack,
  output logic [BYTE_W-1:0]     tx_data,
  output logic                  tx_load,
  input  logic                  tx_ready,
  output logic                  frame_active,
  output logic                  abort
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t               state_q, state_d;
  logic [IW-1:0]        ptr_q, ptr_d;
  logic [IW-1:0]        gidx_q, gidx_d;
  logic [N_REQ-1:0]     gnt_q, gnt_d;
  logic [N_REQ-1:0]     ack_q, ack_d;
  logic [BYTE_W-1:0]    tx_data_q, tx_data_d;
  logic                 tx_load_q, tx_load_d;
  logic                 fa_q, fa_d;
  logic                 abort_q, abort_d;
  logic                 last_q, last_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [TIMER_W-1:0]   gap_q, gap_d;

  logic [BYTE_W-1:0]    req_byte [N_REQ];
  logic [N_REQ-1:0]     pick_oh;
  logic [IW-1:0]        pick_idx;
  logic                 pick_any;
  logic                 cur_req;
  logic                 timer_expire;
  logic                 gap_done;
  logic                 end_frame;
  logic [IW-1:0]        ptr_after;

  rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_pick (
    .req_i    (req),
    .ptr_i    (ptr_q),
    .onehot_o (pick_oh),
    .idx_o    (pick_idx),
    .any_o    (pick_any)
  );

  always_comb begin
    for (int i = 0; i < N_REQ; i++) req_byte[i] = req_data[i*BYTE_W +: BYTE_W];
  end

  assign cur_req      = req[gidx_q];
  assign timer_expire = (timer_q == TIMER_W'(TIMEOUT - 1));
  assign gap_done     = (gap_q == TIMER_W'(GAP_CYCLES - 1));
  assign ptr_after    = (gidx_q == IW'(N_REQ - 1)) ? '0 : gidx_q + IW'(1);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gidx_d    = gidx_q;
    gnt_d     = gnt_q;
    ack_d     = '0;
    tx_data_d = tx_data_q;
    tx_load_d = 1'b0;
    fa_d      = fa_q;
    abort_d   = 1'b0;
    last_d    = last_q;
    end_frame = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_any) begin
          gnt_d   = pick_oh;
          gidx_d  = pick_idx;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (!cur_req) begin
          state_d = WAIT_DATA;
        end else if (tx_ready) begin
          tx_load_d = 1'b1;
          ack_d     = gnt_q;
          tx_data_d = req_byte[gidx_q];
          last_d    = req_last[gidx_q];
          fa_d      = 1'b1;
          state_d   = WAIT_START;
        end
      end
      WAIT_START: begin
        if (!tx_ready) begin
          state_d = WAIT_DONE;
        end else if (timer_expire) begin
          abort_d   = 1'b1;
          end_frame = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (tx_ready) begin
          if (last_q) end_frame = 1'b1;
          else        state_d   = LOAD;
        end
      end
      WAIT_DATA: begin
        if (cur_req) begin
          state_d = LOAD;
        end else if (timer_expire) begin
          abort_d   = 1'b1;
          end_frame = 1'b1;
        end
      end
      GAP: begin
        if (gap_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Normal completion and timeout share one exit: release the grant and rotate priority.
    if (end_frame) begin
      gnt_d   = '0;
      fa_d    = 1'b0;
      ptr_d   = ptr_after;
      state_d = GAP;
    end
  end

  always_comb begin
    timer_d = timer_q;
    gap_d   = gap_q;
    if (state_d != state_q) begin
      timer_d = '0;
      gap_d   = '0;
    end else begin
      if ((state_q == WAIT_START || state_q == WAIT_DATA) && (timer_q != '1))
        timer_d = timer_q + TIMER_W'(1);
      if (state_q == GAP && gap_q != '1)
        gap_d = gap_q + TIMER_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      gidx_q    <= '0;
      gnt_q     <= '0;
      ack_q     <= '0;
      tx_data_q <= '0;
      tx_load_q <= 1'b0;
      fa_q      <= 1'b0;
      abort_q   <= 1'b0;
      last_q    <= 1'b0;
      timer_q   <= '0;
      gap_q     <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gidx_q    <= gidx_d;
      gnt_q     <= gnt_d;
      ack_q     <= ack_d;
      tx_data_q <= tx_data_d;
      tx_load_q <= tx_load_d;
      fa_q      <= fa_d;
      abort_q   <= abort_d;
      last_q    <= last_d;
      timer_q   <= timer_d;
      gap_q     <= gap_d;
    end
  end

  assign gnt          = gnt_q;
  assign ack          = ack_q;
  assign tx_data      = tx_data_q;
  assign tx_load      = tx_load_q;
  assign frame_active = fa_q;
  assign abort        = abort_q;

endmodule
